// File: rtl/instr_feeder.sv
// instr_feeder: host-loaded instruction FIFO that issues one word at a time
// to the processor (Run/DIN) and waits for Done, with a WAIT watchdog.
module instr_feeder #(
  parameter int DEPTH   = 8,   // FIFO entries, power of two, 2..16
  parameter int TIMEOUT = 7    // max WAIT cycles without Done, 1..15
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        WrEn,
  input  logic [15:0] WrData,
  input  logic        Enable,
  input  logic        Done,
  output logic [15:0] DIN,
  output logic        Run,
  output logic        Full,
  output logic        Empty,
  output logic [4:0]  Count,
  output logic        Busy,
  output logic [15:0] Issued,
  output logic        Timeout
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_C  = 5'(DEPTH);
  localparam logic [3:0]  WAIT_MAX = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERROR} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   rptr, wptr;
  logic [4:0]      count;
  logic [15:0]     mem [DEPTH];
  logic [3:0]      wcnt;
  logic            wr_ok, pop, can_issue;

  // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign wr_ok     = WrEn & ~Full;
  assign pop       = (state == S_ISSUE);
  assign can_issue = Enable & ~Empty;

  // Next-state decode; Done only matters in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (can_issue) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (Done)                  state_nxt = can_issue ? S_ISSUE : S_IDLE;
        else if (wcnt == WAIT_MAX) state_nxt = S_ERROR;
      end
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, WAIT watchdog and retired-instruction counter.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state  <= S_IDLE;
      wcnt   <= '0;
      Issued <= '0;
    end else begin
      state <= state_nxt;
      // Held at zero outside WAIT so it always starts clean on entry.
      if (state != S_WAIT) wcnt <= '0;
      else if (!Done)      wcnt <= wcnt + 4'd1;
      if (state == S_WAIT && Done) Issued <= Issued + 16'd1;
    end
  end

  // FIFO storage; contents need no reset since Count gates every read.
  always_ff @(posedge Clock) begin
    if (wr_ok) mem[wptr] <= WrData;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  assign Count   = count;
  assign Full    = (count == DEPTH_C);
  assign Empty   = (count == 5'd0);
  assign Run     = (state == S_ISSUE);
  assign DIN     = (state == S_ISSUE) ? mem[rptr] : 16'h0000;
  assign Busy    = (state == S_ISSUE) || (state == S_WAIT);
  assign Timeout = (state == S_ERROR);

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: a tiny processor stand-in produces Done, a
// transaction-level model predicts flags/counters, and a scoreboard queue
// of expected issued words is checked by an independent Run monitor.
module tb_instr_feeder;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 7;
  localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_ERR = 3;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        WrEn = 1'b0;
  logic [15:0] WrData = '0;
  logic        Enable = 1'b0;
  logic        Done;
  logic [15:0] DIN;
  logic        Run, Full, Empty, Busy, Timeout;
  logic [4:0]  Count;
  logic [15:0] Issued;

  instr_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Resetn(Resetn), .WrEn(WrEn), .WrData(WrData),
    .Enable(Enable), .Done(Done), .DIN(DIN), .Run(Run), .Full(Full),
    .Empty(Empty), .Count(Count), .Busy(Busy), .Issued(Issued),
    .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Processor stand-in: mv (op 000) completes in 2 cycles, others in 4.
  logic       pbusy = 1'b0;
  logic [2:0] pcnt = '0;
  logic [2:0] plat = 3'd2;
  logic       tie0 = 1'b0;
  logic       noise = 1'b0;
  logic       pdone;
  assign pdone = pbusy && (pcnt == plat - 3'd1) && !tie0;
  // Spurious Done pulses only while no instruction is in flight.
  assign Done  = pdone | (noise & ~pbusy);

  always @(posedge Clock) begin
    if (!Resetn) begin
      pbusy <= 1'b0;
      pcnt  <= '0;
    end else if (pbusy) begin
      if (pdone) pbusy <= 1'b0;
      else       pcnt  <= pcnt + 3'd1;
    end else if (Run) begin
      pbusy <= 1'b1;
      pcnt  <= 3'd1;
      plat  <= (DIN[15:13] == 3'b000) ? 3'd2 : 3'd4;
    end
  end

  // Reference model: queue of stored words plus the feeder's phase.
  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  int          mmode = M_IDLE;
  int          mwait = 0;
  logic [15:0] missued = '0;

  task automatic model_edge(input logic wr, input logic [15:0] wd,
                            input logic en, input logic rn, input logic dn);
    int sz;
    sz = mq.size();
    if (!rn) begin
      mq.delete();
      mmode = M_IDLE; mwait = 0; missued = '0;
      return;
    end
    case (mmode)
      M_IDLE: if (en && sz > 0) begin mmode = M_ISSUE; exp_q.push_back(mq[0]); end
      M_ISSUE: begin void'(mq.pop_front()); mmode = M_WAIT; mwait = 0; end
      M_WAIT: begin
        if (dn) begin
          missued = missued + 16'd1;
          if (en && sz > 0) begin mmode = M_ISSUE; exp_q.push_back(mq[0]); end
          else mmode = M_IDLE;
        end else begin
          mwait++;
          if (mwait == TIMEOUT) mmode = M_ERR;
        end
      end
      default: ;
    endcase
    if (wr && sz < DEPTH) mq.push_back(wd);
  endtask

  // One clock: drive inputs, advance the model at the edge, check just after.
  task automatic step(input logic wr, input logic [15:0] wd, input logic en,
                      input logic rn, input logic nz);
    logic d_s;
    WrEn = wr; WrData = wd; Enable = en; Resetn = rn; noise = nz;
    #2;
    d_s = Done;
    @(posedge Clock);
    model_edge(wr, wd, en, rn, d_s);
    #1;
    chk("count",   int'(Count),   mq.size());
    chk("empty",   int'(Empty),   int'(mq.size() == 0));
    chk("full",    int'(Full),    int'(mq.size() == DEPTH));
    chk("run",     int'(Run),     int'(mmode == M_ISSUE));
    chk("busy",    int'(Busy),    int'(mmode == M_ISSUE || mmode == M_WAIT));
    chk("timeout", int'(Timeout), int'(mmode == M_ERR));
    chk("issued",  int'(Issued),  int'(missued));
  endtask

  // Monitor: every Run cycle must present the next expected word; DIN is 0 otherwise.
  always @(negedge Clock) begin
    if (Resetn) begin
      if (Run) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL din_unexpected: got %h, expected no issue at %0t", DIN, $time);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          n_cmp++;
          if (DIN !== e) begin
            n_err++;
            $display("FAIL din: got %h, expected %h at %0t", DIN, e, $time);
          end
        end
      end else begin
        n_cmp++;
        if (DIN !== 16'h0000) begin
          n_err++;
          $display("FAIL din_idle: got %h, expected 0000 at %0t", DIN, $time);
        end
      end
    end
  end

  task automatic do_reset();
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 1, 0);
  endtask

  initial begin
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 1, 0);

    // mv r0,#5 alone
    step(1, 16'h1005, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 16'h0, 1, 1, 0);

    // mv then add back-to-back
    step(1, 16'h1005, 1, 1, 0);
    step(1, 16'h5003, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 16'h0, 1, 1, 0);

    // overfill with Enable low, then drain in order
    do_reset();
    for (int i = 0; i <= DEPTH; i++) step(1, 16'h1000 + 16'(i), 0, 1, 0);
    for (int i = 0; i < 30; i++) step(0, 16'h0, 1, 1, 0);

    // full FIFO with write during the ISSUE pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 16'h5000 + 16'(i), 0, 1, 0);
    step(1, 16'hAAAA, 1, 1, 0);
    step(1, 16'hBBBB, 1, 1, 0);
    step(1, 16'h1CCC, 1, 1, 0);
    for (int i = 0; i < 45; i++) step(0, 16'h0, 1, 1, 0);

    // randomized traffic with spurious Done outside WAIT
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      step(($urandom % 5) < 2, w, ($urandom % 8) != 0, 1, ($urandom % 4) == 0);
    end
    for (int i = 0; i < 45; i++) step(0, 16'h0, 1, 1, 0);

    // watchdog: Done never arrives; writes still accepted in ERROR
    do_reset();
    tie0 = 1'b1;
    step(1, 16'h5001, 1, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 16'h0, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 16'($urandom), 1, 1, 0);
    tie0 = 1'b0;
    do_reset();

    // reset during WAIT with 3 entries queued
    for (int i = 0; i < 4; i++) step(1, 16'h5100 + 16'(i), 0, 1, 0);
    step(0, 16'h0, 1, 1, 0);
    step(0, 16'h0, 1, 1, 0);
    step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 1, 1, 0);
    step(0, 16'h0, 0, 1, 0);

    @(negedge Clock);
    #1;
    chk("exp_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
